// File: rtl/rocketcpu_param_slew_pkg.sv
// Shared definitions for the parameter slew limiter: sweep FSM encoding and
// the helper that locates a channel inside the packed parameter bus.
package rocketcpu_param_slew_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rocketcpu_slew_step.sv
// One channel's slew update: moves cur toward tgt by at most step.
// step == 0 means bypass. The magnitude compare keeps cur+/-step from wrapping.
module rocketcpu_slew_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] tgt_i,
    input  logic [WIDTH-1:0] step_i,
    output logic [WIDTH-1:0] next_o,
    output logic             settled_o
);

    logic             up;
    logic [WIDTH-1:0] diff;

    always_comb begin
        up     = (tgt_i > cur_i);
        diff   = up ? (tgt_i - cur_i) : (cur_i - tgt_i);
        next_o = tgt_i;
        if ((step_i != '0) && (diff > step_i)) begin
            next_o = up ? (cur_i + step_i) : (cur_i - step_i);
        end
        settled_o = (next_o == tgt_i);
    end

endmodule

// File: rtl/rocketcpu_param_slew.sv
// Slew-limits CPU-written parameter words; on each tick the channels are
// swept serially, one per clock, through a single shared step datapath.
module rocketcpu_param_slew
    import rocketcpu_param_slew_pkg::*;
#(
    parameter int unsigned CHANNELS = 12,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned IDX_W    = 6
) (
    input  logic                      i_wb_clk,
    input  logic                      i_wb_rst_n,
    input  logic                      i_tick,
    input  logic [WIDTH-1:0]          i_step,
    input  logic [CHANNELS*WIDTH-1:0] i_param,
    output logic [CHANNELS*WIDTH-1:0] o_param,
    output logic [CHANNELS-1:0]       o_settled,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic [WIDTH-1:0]    param_q [CHANNELS];
    logic [CHANNELS-1:0] settled_q;

    logic [WIDTH-1:0]    cur, tgt, nxt;
    logic                nxt_settled;

    // Targets are read live from the bus at the channel's own update edge.
    always_comb begin
        cur = '0;
        tgt = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur = param_q[k];
                tgt = i_param[ch_lsb(k, WIDTH) +: WIDTH];
            end
        end
    end

    rocketcpu_slew_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .cur_i    (cur),
        .tgt_i    (tgt),
        .step_i   (i_step),
        .next_o   (nxt),
        .settled_o(nxt_settled)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (i_tick) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (i_tick) begin
                    overrun_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                param_q[k] <= '0;
            end
            settled_q <= '0;
        end else if (state_q == SWEEP) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    param_q[k]   <= nxt;
                    settled_q[k] <= nxt_settled;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_pack
        assign o_param[g*WIDTH +: WIDTH] = param_q[g];
    end

    assign o_settled = settled_q;
    assign o_busy    = (state_q == SWEEP);
    assign o_done    = done_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_rocketcpu_param_slew.sv
// Randomised scoreboard bench for the serial parameter slew limiter.
module tb_rocketcpu_param_slew;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned IW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tick = 1'b0;
    logic [W-1:0]    step = '0;
    logic [CH*W-1:0] tgt = '0;
    logic [CH*W-1:0] o_param;
    logic [CH-1:0]   o_settled;
    logic            o_busy, o_done, o_overrun;

    rocketcpu_param_slew #(
        .CHANNELS(CH),
        .WIDTH   (W),
        .IDX_W   (IW)
    ) dut (
        .i_wb_clk  (clk),
        .i_wb_rst_n(rst_n),
        .i_tick    (tick),
        .i_step    (step),
        .i_param   (tgt),
        .o_param   (o_param),
        .o_settled (o_settled),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_overrun (o_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [W-1:0]  m_cur [CH];
    logic [CH-1:0] m_set;

    typedef struct packed {
        logic [CH*W-1:0] p;
        logic [CH-1:0]   s;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [CH*W-1:0] act, input logic [CH*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference rule evaluated with 64-bit arithmetic so nothing can wrap.
    function automatic logic [W-1:0] slew(input logic [W-1:0] c, input logic [W-1:0] t, input logic [W-1:0] s);
        longint lc, lt, ls;
        lc = longint'(c);
        lt = longint'(t);
        ls = longint'(s);
        if (ls == 0 || lc == lt) return t;
        if (lt > lc) return (lt - lc <= ls) ? t : W'(lc + ls);
        return (lc - lt <= ls) ? t : W'(lc - ls);
    endfunction

    function automatic logic [CH*W-1:0] model_bus();
        logic [CH*W-1:0] b;
        for (int k = 0; k < int'(CH); k++) b[k*W +: W] = m_cur[k];
        return b;
    endfunction

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return '1;
            2: return W'($urandom);
            default: return W'($urandom_range(0, 200));
        endcase
    endfunction

    task automatic set_tgt(input int k, input logic [W-1:0] v);
        tgt[k*W +: W] = v;
    endtask

    task automatic model_reset();
        for (int k = 0; k < int'(CH); k++) m_cur[k] = '0;
        m_set = '0;
        sb.delete();
    endtask

    // One full sweep; the expected result is queued for the monitor.
    task automatic sweep(input bit mid_change, input bit second_tick);
        exp_t e;
        @(negedge clk);
        tick = 1'b1;
        for (int k = 0; k < int'(CH); k++) begin
            @(negedge clk);
            tick = second_tick && (k == 1);
            chk("busy_in_sweep", CH*W'(o_busy), CH*W'(1));
            chk("done_low_in_sweep", CH*W'(o_done), '0);
            if (mid_change && $urandom_range(0, 1) == 1) begin
                set_tgt(int'($urandom_range(0, CH - 1)), rand_val());
            end
            m_cur[k] = slew(m_cur[k], tgt[k*W +: W], step);
            m_set[k] = (m_cur[k] == tgt[k*W +: W]);
        end
        e.p = model_bus();
        e.s = m_set;
        sb.push_back(e);
        @(negedge clk);
        tick = 1'b0;
        chk("done_pulse", CH*W'(o_done), CH*W'(1));
        chk("busy_after_sweep", CH*W'(o_busy), '0);
        @(negedge clk);
        chk("done_one_cycle", CH*W'(o_done), '0);
    endtask

    // Monitor: every o_done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_done actual=done expected=no_done");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_param", o_param, e.p);
                chk("sb_settled", CH*W'(o_settled), CH*W'(e.s));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_param", o_param, '0);
        chk("reset_settled", CH*W'(o_settled), '0);
        chk("reset_busy", CH*W'(o_busy), '0);
        chk("reset_overrun", CH*W'(o_overrun), '0);

        repeat (50) @(negedge clk);
        chk("idle_param", o_param, '0);
        chk("idle_busy", CH*W'(o_busy), '0);
        chk("idle_settled", CH*W'(o_settled), '0);

        // Rise: ch0 walks 30, 60, 90, 100
        step = 32'd30;
        set_tgt(0, 32'd100);
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] exp_rise [4];
            exp_rise[0] = 32'd30;
            exp_rise[1] = 32'd60;
            exp_rise[2] = 32'd90;
            exp_rise[3] = 32'd100;
            sweep(1'b0, 1'b0);
            chk("rise_ch0", CH*W'(o_param[0 +: W]), CH*W'(exp_rise[i]));
            chk("rise_settled0", CH*W'(o_settled[0]), CH*W'(i == 3));
        end

        // Bypass
        step = '0;
        set_tgt(0, 32'd7); set_tgt(1, 32'd8); set_tgt(2, 32'd9); set_tgt(3, 32'd10);
        sweep(1'b0, 1'b0);
        chk("bypass_param", o_param, {32'd10, 32'd9, 32'd8, 32'd7});
        chk("bypass_settled", CH*W'(o_settled), CH*W'(4'b1111));

        // Extremes on ch1: no wrap when falling from all-ones
        set_tgt(1, 32'hFFFF_FFFF);
        sweep(1'b0, 1'b0);
        chk("ext_load", CH*W'(o_param[W +: W]), CH*W'(32'hFFFF_FFFF));
        step = 32'h8000_0000;
        set_tgt(1, 32'h0000_0005);
        set_tgt(2, 32'hFFFF_FFFF);
        sweep(1'b0, 1'b0);
        chk("ext_fall1", CH*W'(o_param[W +: W]), CH*W'(32'h7FFF_FFFF));
        chk("ext_rise_top", CH*W'(o_param[2*W +: W]), CH*W'(32'h8000_0009));
        chk("ext_settled1", CH*W'(o_settled[1]), '0);
        sweep(1'b0, 1'b0);
        chk("ext_fall2", CH*W'(o_param[W +: W]), CH*W'(32'h0000_0005));
        chk("ext_top", CH*W'(o_param[2*W +: W]), CH*W'(32'hFFFF_FFFF));
        chk("ext_settled", CH*W'(o_settled[2:1]), CH*W'(2'b11));

        // Overrun: second tick inside a sweep is ignored and sticks
        chk("overrun_clear", CH*W'(o_overrun), '0);
        step = 32'd3;
        set_tgt(0, 32'd50);
        sweep(1'b0, 1'b1);
        chk("overrun_set", CH*W'(o_overrun), CH*W'(1));
        repeat (3) sweep(1'b0, 1'b0);
        chk("overrun_sticky", CH*W'(o_overrun), CH*W'(1));

        // Randomised sweeps with live target/step changes
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < int'(CH); k++) set_tgt(k, rand_val());
            case ($urandom_range(0, 3))
                0: step = '0;
                1: step = W'($urandom_range(1, 64));
                2: step = W'($urandom);
                default: step = 32'h8000_0000;
            endcase
            sweep(1'b1, 1'b0);
        end

        // Async reset mid-sweep at idx == 2
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_param", o_param, '0);
        chk("arst_settled", CH*W'(o_settled), '0);
        chk("arst_busy", CH*W'(o_busy), '0);
        chk("arst_overrun", CH*W'(o_overrun), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step = 32'd1000;
        for (int k = 0; k < int'(CH); k++) set_tgt(k, rand_val());
        sweep(1'b0, 1'b0);
        chk("post_reset_overrun", CH*W'(o_overrun), '0);

        repeat (3) @(negedge clk);
        chk("sb_drained", CH*W'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
